prog_delay_ctrl: RTL
====================

// Module: prog_delay_ctrl
// PURPOSE
//  Sample-strobe-driven programmable delay controller for EEG channel streams.
//  - Owns a circular register buffer and delays DIN by CFG_DLY input samples, counted in IN_VLD strobes rather than clock cycles.
//  - Sequences fill and run after reset and after every reconfiguration.
//  - Sits between the front-end sample stage and feature pipelines, where the fixed-stage delay primitive is insufficient.
// PARAMETERS
//  DATA_WIDTH  8                       sample width
//  MAX_DELAY   16                      max delay in samples (ring depth), >=1
//  DLY_W       $clog2(MAX_DELAY+1)     width of delay config
//  DLY_RST     0                       active delay after reset, <= MAX_DELAY
// PORTS
//  CLK       in   1           clock
//  RST_N     in   1           reset, asynchronous, active-low
//  CFG_DLY   in   DLY_W       requested delay in samples
//  CFG_LOAD  in   1           1-cycle pulse: latch CFG_DLY, restart fill
//  IN_VLD    in   1           sample strobe, 1 cycle per sample
//  DIN       in   DATA_WIDTH  input sample, qualified by IN_VLD
//  OUT_VLD   out  1           delayed-sample strobe
//  DOUT      out  DATA_WIDTH  delayed sample, held between strobes
//  CFG_BUSY  out  1           1 while in FILL state
//  ACT_DLY   out  DLY_W       delay currently in force
// BEHAVIOUR
//  - Reset values: OUT_VLD=0, DOUT=0, wp=0, fill_cnt=0, ACT_DLY=DLY_RST.
//    State after reset is FILL if DLY_RST>0, else RUN. CFG_BUSY follows state.
//  - Clamping: CFG_DLY > MAX_DELAY is clamped to MAX_DELAY when latched.
//  - Write path, per IN_VLD cycle:
//    - ring[wp] <= DIN.
//    - wp <= (wp==MAX_DELAY-1) ? 0 : wp+1, wrapping modulo MAX_DELAY.
//  - Read path:
//    - Read address is (wp - ACT_DLY) mod MAX_DELAY.
//    - The ring is read before that same cycle's write.
//    - ACT_DLY=MAX_DELAY therefore reads the entry being overwritten.
//    - ACT_DLY=0 bypasses the ring: DOUT takes DIN.
//  - Latency:
//    - DOUT/OUT_VLD are registered; OUT_VLD rises in the cycle after the qualifying IN_VLD.
//    - OUT_VLD is a 1-cycle pulse.
//    - DOUT updates only with OUT_VLD and holds otherwise.
//  - FSM, 2 states:
//    - FILL:
//      - IN_VLD writes the ring and increments fill_cnt.
//      - No OUT_VLD is produced.
//      - When an IN_VLD arrives with fill_cnt==ACT_DLY-1 -> RUN with fill_cnt=0.
//        That strobe itself is not output.
//    - RUN: every IN_VLD produces OUT_VLD next cycle.
//  - CFG_LOAD (accepted in either state):
//    - ACT_DLY <= clamp(CFG_DLY); fill_cnt <= 0.
//    - Next state is FILL, or RUN if the new delay is 0.
//    - Ring contents and wp are not cleared; stale data is never output because FILL suppresses it.
//  - CFG_LOAD and IN_VLD in the same cycle:
//    - The sample is written.
//    - It counts as strobe 0 under the NEW delay: fill_cnt <= 1, or immediate output if the new delay is 0.
//    - No output is produced under the old delay.
//    - If the new delay is 1, the state goes directly to RUN.
//  - CFG_LOAD during FILL restarts the fill with the new value.
//  - Reset mid-stream: all state returns to reset values asynchronously.
//    Any pending OUT_VLD is dropped.
//  - Idle: IN_VLD=0 leaves the ring, wp and fill_cnt unchanged.
// STRUCTURE
//  - Shared package eeg_dly_pkg:
//    - localparam state encoding: ST_FILL=1'b0, ST_RUN=1'b1.
//    - clamp function for the delay value.
//  - Sub-module delay_ring_buf (DATA_WIDTH, MAX_DELAY):
//    - Register array with 1 write port and 1 asynchronous read port.
//    - Write pointer wrap logic.
//    - No reset on the data array.
//  - Top: FSM, fill counter, ACT_DLY register, output register.
// TESTING
//  1. Reset with DLY_RST=0, then IN_VLD each cycle with DIN=1,2,3:
//     - OUT_VLD rises 1 cycle later.
//     - DOUT=1,2,3.
//     - CFG_BUSY=0 throughout.
//  2. CFG_LOAD with CFG_DLY=3, then samples 10..17 on every 2nd cycle:
//     - CFG_BUSY high for 3 strobes.
//     - First OUT_VLD follows sample 13 with DOUT=10, then 11, 12, ...
//  3. CFG_DLY=MAX_DELAY (16), 40 contiguous samples:
//     - The pointer wraps twice.
//     - Output k equals input k-16 exactly.
//     - Exactly 24 OUT_VLD pulses.
//  4. CFG_DLY=20 with MAX_DELAY=16:
//     - ACT_DLY=16.
//     - Behaviour is identical to scenario 3.
//  5. CFG_LOAD coincident with IN_VLD (new delay 2) while in RUN with delay 5:
//     - The coincident sample is strobe 0.
//     - One further strobe suppressed.
//     - Third strobe outputs the coincident sample.
//  6. RST_N asserted mid-FILL and mid-RUN (one cycle after IN_VLD):
//     - OUT_VLD stays 0.
//     - DOUT=0 and ACT_DLY=DLY_RST immediately.
//     - Operation restarts cleanly.

Source files
------------

// File: rtl/eeg_dly_pkg.sv
// Shared definitions for the programmable sample-delay controller.
//  dly_state_t : controller state (FILL while the ring is being primed, RUN when emitting)
//  clamp_dly   : limits a requested delay to the ring depth
package eeg_dly_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } dly_state_t;

  function automatic int unsigned clamp_dly(input int unsigned req,
                                            input int unsigned max_dly);
    return (req > max_dly) ? max_dly : req;
  endfunction

endpackage

// File: rtl/prog_delay_ctrl_if.sv
// Sample stream bundle between the front-end sample stage and the delay controller.
//  IN_VLD / DIN   : input sample strobe and data (source -> controller)
//  OUT_VLD / DOUT : delayed sample strobe and data (controller -> sink)
//  master : stream source/sink side (drives IN_VLD, DIN)
//  slave  : delay controller side (drives OUT_VLD, DOUT)
interface prog_delay_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  IN_VLD;
  logic [DATA_WIDTH-1:0] DIN;
  logic                  OUT_VLD;
  logic [DATA_WIDTH-1:0] DOUT;

  modport master (output IN_VLD, DIN, input  OUT_VLD, DOUT);
  modport slave  (input  IN_VLD, DIN, output OUT_VLD, DOUT);
endinterface

// File: rtl/delay_ring_buf.sv
// Circular register buffer with one write port and one asynchronous read port.
//  clk, rst_n : clock, asynchronous active-low reset (write pointer only)
//  wr_en      : write DIN-side data at the write pointer and advance it
//  wr_data    : data to write
//  rd_dly     : read distance behind the write pointer (0..MAX_DELAY)
//  rd_data    : ring[(wp - rd_dly) mod MAX_DELAY], read before this cycle's write
module delay_ring_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_DELAY  = 16,
  parameter int unsigned DLY_W      = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DLY_W-1:0]      rd_dly,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned SW = DLY_W + 1;

  logic [DATA_WIDTH-1:0] ring [MAX_DELAY];
  logic [AW-1:0]         wp;
  logic [SW-1:0]         wp_ext;
  logic [SW-1:0]         rd_ext;
  logic [AW-1:0]         rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
    end else if (wr_en) begin
      wp <= (wp == AW'(MAX_DELAY - 1)) ? '0 : wp + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ring[wp] <= wr_data;
    end
  end

  // Modulo subtraction without a divider: add the depth back when wp < rd_dly.
  // rd_dly == MAX_DELAY lands on wp itself, i.e. the entry about to be overwritten.
  always_comb begin
    wp_ext = SW'(wp);
    if (wp_ext >= SW'(rd_dly)) begin
      rd_ext = wp_ext - SW'(rd_dly);
    end else begin
      rd_ext = wp_ext + SW'(MAX_DELAY) - SW'(rd_dly);
    end
    rd_addr = AW'(rd_ext);
    rd_data = ring[rd_addr];
  end

endmodule

// File: rtl/prog_delay_ctrl.sv
// Programmable delay controller for EEG channel sample streams. Delays DIN by
// ACT_DLY input samples (counted in IN_VLD strobes), priming the ring in FILL
// after reset and after every reconfiguration so stale data is never emitted.
//  CLK, RST_N : clock, asynchronous active-low reset
//  CFG_DLY    : requested delay in samples (clamped to MAX_DELAY on load)
//  CFG_LOAD   : 1-cycle pulse, latches CFG_DLY and restarts the fill
//  strm       : sample stream (IN_VLD/DIN in, OUT_VLD/DOUT out)
//  CFG_BUSY   : high while filling
//  ACT_DLY    : delay currently in force
module prog_delay_ctrl
  import eeg_dly_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_DELAY  = 16,
  parameter int unsigned DLY_W      = $clog2(MAX_DELAY + 1),
  parameter int unsigned DLY_RST    = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [DLY_W-1:0]     CFG_DLY,
  input  logic                 CFG_LOAD,
  prog_delay_ctrl_if.slave     strm,
  output logic                 CFG_BUSY,
  output logic [DLY_W-1:0]     ACT_DLY
);

  localparam dly_state_t ST_AFTER_RST = (DLY_RST > 0) ? ST_FILL : ST_RUN;

  dly_state_t            state, state_n;
  logic [DLY_W-1:0]      fill_cnt, fill_n;
  logic [DLY_W-1:0]      act_n;
  logic [DLY_W-1:0]      cfg_clamped;
  logic                  emit;
  logic [DATA_WIDTH-1:0] emit_data;
  logic [DATA_WIDTH-1:0] rd_data;

  delay_ring_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DELAY  (MAX_DELAY),
    .DLY_W      (DLY_W)
  ) u_ring (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (strm.IN_VLD),
    .wr_data (strm.DIN),
    .rd_dly  (ACT_DLY),
    .rd_data (rd_data)
  );

  assign cfg_clamped = DLY_W'(clamp_dly(32'(CFG_DLY), MAX_DELAY));
  assign CFG_BUSY    = (state == ST_FILL);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_AFTER_RST;
      fill_cnt     <= '0;
      ACT_DLY      <= DLY_W'(DLY_RST);
      strm.OUT_VLD <= 1'b0;
      strm.DOUT    <= '0;
    end else begin
      state        <= state_n;
      fill_cnt     <= fill_n;
      ACT_DLY      <= act_n;
      strm.OUT_VLD <= emit;
      if (emit) begin
        strm.DOUT <= emit_data;
      end
    end
  end

  always_comb begin
    state_n   = state;
    fill_n    = fill_cnt;
    act_n     = ACT_DLY;
    emit      = 1'b0;
    emit_data = (ACT_DLY == '0) ? strm.DIN : rd_data;

    if (CFG_LOAD) begin
      // A coincident sample is strobe 0 under the new delay; nothing is
      // emitted under the old one.
      act_n  = cfg_clamped;
      fill_n = '0;
      if (cfg_clamped == '0) begin
        state_n   = ST_RUN;
        emit      = strm.IN_VLD;
        emit_data = strm.DIN;
      end else if (strm.IN_VLD) begin
        if (cfg_clamped == DLY_W'(1)) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_FILL;
          fill_n  = DLY_W'(1);
        end
      end else begin
        state_n = ST_FILL;
      end
    end else if (strm.IN_VLD) begin
      if (state == ST_FILL) begin
        if ((fill_cnt + DLY_W'(1)) == ACT_DLY) begin
          state_n = ST_RUN;
          fill_n  = '0;
        end else begin
          fill_n = fill_cnt + DLY_W'(1);
        end
      end else begin
        emit = 1'b1;
      end
    end
  end

endmodule
